lsq_issue: RTL and testbench

- In-order load/store queue directly upstream of the data cache.
- Accepts memory micro-ops from the address-generation stage. Buffers up to DEPTH entries and issues them one per cycle to the cache, asserting read_en or write_en.
- Loads whose word address matches an older queued SW are completed directly from the queue (store-to-load forwarding) and never reach the cache.
- Flush support for branch mispredict recovery.

---
 rtl/lsq_pkg.sv | 47 ++++
 rtl/lsq_issue_if.sv | 42 ++++
 rtl/lsq_fwd_match.sv | 44 ++++
 rtl/lsq_issue.sv | 160 ++++++++++++++++
 tb/tb_lsq_issue.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsq_pkg.sv
// Shared op encodings, queue entry layout and small decode helpers for the
// load/store issue queue.
package lsq_pkg;

    typedef enum logic [3:0] {
        OP_LB = 4'd7,
        OP_LW = 4'd8,
        OP_SB = 4'd9,
        OP_SW = 4'd10
    } op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [5:0]  rtag;
        logic [3:0]  optype;
        logic [31:0] data;
    } entry_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SW);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Shapes a forwarded store word into the load result: full word for LW,
    // zero-extended byte lane for LB.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  sel,
                                                 input logic        is_byte);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return is_byte ? {24'd0, b} : word;
    endfunction

endpackage

// File: rtl/lsq_issue_if.sv
// Upstream micro-op port, cache issue port and forward result bundled as one
// interface; master is the surrounding pipeline, slave is the queue.
interface lsq_issue_if #(
    parameter int PTR_W = 3
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_addr;
    logic [5:0]       in_reg;
    logic [3:0]       in_optype;
    logic [31:0]      in_data;
    logic             cache_busy;

    logic [31:0]      inst_pc;
    logic [31:0]      address_in;
    logic [5:0]       reg_in;
    logic [3:0]       optype;
    logic [31:0]      dataSw;
    logic             read_en;
    logic             write_en;

    logic             fwd_valid;
    logic [5:0]       fwd_reg;
    logic [31:0]      fwd_data;
    logic [PTR_W:0]   count;

    modport master (
        output flush, in_valid, in_pc, in_addr, in_reg, in_optype, in_data,
               cache_busy,
        input  in_ready, inst_pc, address_in, reg_in, optype, dataSw,
               read_en, write_en, fwd_valid, fwd_reg, fwd_data, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_addr, in_reg, in_optype, in_data,
               cache_busy,
        output in_ready, inst_pc, address_in, reg_in, optype, dataSw,
               read_en, write_en, fwd_valid, fwd_reg, fwd_data, count
    );
endinterface

// File: rtl/lsq_fwd_match.sv
// Priority search of the queue for the youngest same-word store feeding an
// incoming load; a younger SB to that word cancels the SW hit.
module lsq_fwd_match
    import lsq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic [PTR_W-1:0]       head,
    input  logic [DEPTH-1:0]       ent_valid,
    input  logic [DEPTH-1:0][29:0] ent_word,
    input  logic [DEPTH-1:0][3:0]  ent_op,
    input  logic [DEPTH-1:0][31:0] ent_data,
    input  logic [29:0]            ld_word,
    input  logic [1:0]             ld_byte,
    input  logic                   ld_is_byte,
    output logic                   hit,
    output logic [PTR_W-1:0]       idx,
    output logic [31:0]            data
);

    // Walk oldest to youngest from head so the last store seen is the youngest.
    always_comb begin
        logic [PTR_W-1:0] pos;
        // NOTE: every output gets a default before the loop so no latch is inferred.
        hit = 1'b0;
        idx = '0;
        pos = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pos = head + PTR_W'(k);
            if (ent_valid[pos] && (ent_word[pos] == ld_word)) begin
                if (ent_op[pos] == OP_SW) begin
                    hit = 1'b1;
                    idx = pos;
                end else if (ent_op[pos] == OP_SB) begin
                    hit = 1'b0;
                end
            end
        end
    end

    assign data = load_extract(ent_data[idx], ld_byte, ld_is_byte);

endmodule

// File: rtl/lsq_issue.sv
// In-order load/store queue in front of the data cache: buffers micro-ops,
// issues one per cycle, and completes loads from older queued SWs.
module lsq_issue
    import lsq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    lsq_issue_if.slave  bus
);

    localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    entry_t                 mem [DEPTH];
    logic [DEPTH-1:0]       valid_q;
    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [PTR_W:0]         count_q;

    entry_t                 iss_q;
    logic                   read_en_q;
    logic                   write_en_q;
    logic                   fwd_valid_q;
    logic [5:0]             fwd_reg_q;
    logic [31:0]            fwd_data_q;

    entry_t                 in_ent;
    logic                   in_ready;
    logic                   accept;
    logic                   enq;
    logic                   deq;
    logic                   fwd_hit;
    logic                   fwd_take;
    logic [PTR_W-1:0]       fwd_idx;
    logic [31:0]            fwd_word;
    logic [DEPTH-1:0][29:0] ent_word;
    logic [DEPTH-1:0][3:0]  ent_op;
    logic [DEPTH-1:0][31:0] ent_data;

    assign in_ent = '{pc:     bus.in_pc,
                      addr:   bus.in_addr,
                      rtag:   bus.in_reg,
                      optype: bus.in_optype,
                      data:   bus.in_data};

    // Full/empty comes from count; head == tail is ambiguous on its own.
    assign in_ready = (count_q != FULL);
    assign accept   = bus.in_valid & in_ready & is_legal(bus.in_optype) & ~bus.flush;
    assign fwd_take = accept & is_load(bus.in_optype) & fwd_hit;
    assign enq      = accept & ~fwd_take;
    assign deq      = (count_q != '0) & ~bus.cache_busy & ~bus.flush;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_word[i] = mem[i].addr[31:2];
            ent_op[i]   = mem[i].optype;
            ent_data[i] = mem[i].data;
        end
    end

    lsq_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd_match (
        .head       (head_q),
        .ent_valid  (valid_q),
        .ent_word   (ent_word),
        .ent_op     (ent_op),
        .ent_data   (ent_data),
        .ld_word    (bus.in_addr[31:2]),
        .ld_byte    (bus.in_addr[1:0]),
        .ld_is_byte (bus.in_optype == OP_LB),
        .hit        (fwd_hit),
        .idx        (fwd_idx),
        .data       (fwd_word)
    );

    // NOTE: the entry storage has no reset; valid_q and count_q alone decide
    // which slots are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail_q] <= in_ent;
        end
    end

    // NOTE: all state uses non-blocking assignment so every term above sees
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            iss_q       <= '0;
            read_en_q   <= 1'b0;
            write_en_q  <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_reg_q   <= '0;
            fwd_data_q  <= '0;
        end else if (bus.flush) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            read_en_q   <= 1'b0;
            write_en_q  <= 1'b0;
            fwd_valid_q <= 1'b0;
        end else begin
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_ONE;
            end

            if (deq) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_ONE;
                iss_q           <= mem[head_q];
                read_en_q       <= is_load(mem[head_q].optype);
                write_en_q      <= is_store(mem[head_q].optype);
            end else begin
                read_en_q  <= 1'b0;
                write_en_q <= 1'b0;
            end

            unique case ({enq, deq})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: ;
            endcase

            fwd_valid_q <= fwd_take;
            if (fwd_take) begin
                fwd_reg_q  <= bus.in_reg;
                fwd_data_q <= fwd_word;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.inst_pc    = iss_q.pc;
    assign bus.address_in = iss_q.addr;
    assign bus.reg_in     = iss_q.rtag;
    assign bus.optype     = iss_q.optype;
    assign bus.dataSw     = iss_q.data;
    assign bus.read_en    = read_en_q;
    assign bus.write_en   = write_en_q;
    assign bus.fwd_valid  = fwd_valid_q;
    assign bus.fwd_reg    = fwd_reg_q;
    assign bus.fwd_data   = fwd_data_q;
    assign bus.count      = count_q;

    // A forward may only come from a live SW slot.
    a_fwd_from_sw: assert property (@(posedge clk) disable iff (rst)
        fwd_take |-> (valid_q[fwd_idx] && (mem[fwd_idx].optype == OP_SW)));

endmodule

// File: tb/tb_lsq_issue.sv
// Scoreboard bench for lsq_issue: expected issues/forwards are queued when
// stimulus is driven and compared when the queue produces them.
module tb_lsq_issue;
    import lsq_pkg::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    typedef struct packed {
        logic [5:0]  rtag;
        logic [31:0] data;
    } fwd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsq_issue_if #(.PTR_W(PTR_W)) bus ();

    lsq_issue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    entry_t exp_iss [$];
    fwd_t   exp_fwd [$];
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     mon_en  = 1'b0;
    entry_t mon_e;
    fwd_t   mon_f;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare every cache issue and every forward pulse against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.read_en || bus.write_en) begin
                if (exp_iss.size() == 0) begin
                    check("spurious_issue", {bus.read_en, bus.write_en}, 0);
                end else begin
                    mon_e = exp_iss.pop_front();
                    check("iss_pc",     bus.inst_pc,    mon_e.pc);
                    check("iss_addr",   bus.address_in, mon_e.addr);
                    check("iss_reg",    bus.reg_in,     mon_e.rtag);
                    check("iss_optype", bus.optype,     mon_e.optype);
                    check("iss_data",   bus.dataSw,     mon_e.data);
                    check("iss_rd",     bus.read_en,  (mon_e.optype == 4'd7) || (mon_e.optype == 4'd8));
                    check("iss_wr",     bus.write_en, (mon_e.optype == 4'd9) || (mon_e.optype == 4'd10));
                end
            end
            if (bus.fwd_valid) begin
                if (exp_fwd.size() == 0) begin
                    check("spurious_fwd", bus.fwd_valid, 0);
                end else begin
                    mon_f = exp_fwd.pop_front();
                    check("fwd_reg",  bus.fwd_reg,  mon_f.rtag);
                    check("fwd_data", bus.fwd_data, mon_f.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] addr,
                          input logic [5:0] rtag, input logic [31:0] data);
        bus.in_valid  = 1'b1;
        bus.in_optype = op;
        bus.in_pc     = pc;
        bus.in_addr   = addr;
        bus.in_reg    = rtag;
        bus.in_data   = data;
    endtask

    // kind: 0 = expect a later cache issue, 1 = expect a forward of fdata, 2 = expect rejection
    task automatic send(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] addr,
                        input logic [5:0] rtag, input logic [31:0] data, input int kind,
                        input logic [31:0] fdata);
        set_op(op, pc, addr, rtag, data);
        if (kind == 0) exp_iss.push_back(entry_t'{pc, addr, rtag, op, data});
        else if (kind == 1) exp_fwd.push_back(fwd_t'{rtag, fdata});
        step();
        bus.in_valid = 1'b0;
    endtask

    // Hold in_valid until the queue has room, then expect a cache issue.
    task automatic send_wait(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] addr,
                             input logic [5:0] rtag, input logic [31:0] data);
        int waited = 0;
        set_op(op, pc, addr, rtag, data);
        while (!bus.in_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", bus.in_ready, 1);
            bus.in_valid = 1'b0;
        end else begin
            exp_iss.push_back(entry_t'{pc, addr, rtag, op, data});
            step();
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 64 && bus.count != 0; i++) step();
        check(tag, bus.count, 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_pc      = '0;
        bus.in_addr    = '0;
        bus.in_reg     = '0;
        bus.in_optype  = '0;
        bus.in_data    = '0;
        bus.cache_busy = 1'b0;
        #2 rst = 1'b1;
        #10;
        check("rst_count",    bus.count,      0);
        check("rst_in_ready", bus.in_ready,   1);
        check("rst_read_en",  bus.read_en,    0);
        check("rst_write_en", bus.write_en,   0);
        check("rst_fwd",      bus.fwd_valid,  0);
        check("rst_addr",     bus.address_in, 0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Basic LW: accepted at one edge, issued at the next.
        send(OP_LW, 32'h1000_0000, 32'h100, 6'd5, 32'h0, 0, 0);
        check("t1_count", bus.count, 1);
        check("t1_rd_early", bus.read_en, 0);
        step();
        check("t1_read_en", bus.read_en,    1);
        check("t1_addr",    bus.address_in, 32'h100);
        check("t1_reg",     bus.reg_in,     5);
        check("t1_optype",  bus.optype,     8);
        step();
        check("t1_read_drop", bus.read_en, 0);
        check("t1_count_end", bus.count,   0);

        // Store-to-load forwarding, byte lanes and youngest-SW priority.
        bus.cache_busy = 1'b1;
        send(OP_SW, 32'h1000_0010, 32'h200, 6'd0, 32'hDEAD_BEEF, 0, 0);
        send(OP_LB, 32'h1000_0014, 32'h203, 6'd9, 32'h0, 1, 32'h0000_00DE);
        check("t2_fwd_valid", bus.fwd_valid, 1);
        check("t2_fwd_reg",   bus.fwd_reg,   9);
        check("t2_fwd_data",  bus.fwd_data,  32'h0000_00DE);
        check("t2_count",     bus.count,     1);
        send(OP_LB, 32'h1000_0018, 32'h201, 6'd11, 32'h0, 1, 32'h0000_00BE);
        check("t2_lb1_data", bus.fwd_data, 32'h0000_00BE);
        send(OP_LW, 32'h1000_001C, 32'h200, 6'd10, 32'h0, 1, 32'hDEAD_BEEF);
        check("t2_lw_data", bus.fwd_data, 32'hDEAD_BEEF);
        send(OP_SW, 32'h1000_0020, 32'h200, 6'd0, 32'h1234_5678, 0, 0);
        send(OP_LW, 32'h1000_0024, 32'h200, 6'd12, 32'h0, 1, 32'h1234_5678);
        check("t2_young_data", bus.fwd_data, 32'h1234_5678);
        check("t2_count2",     bus.count,    2);
        step();
        check("t2_fwd_pulse", bus.fwd_valid, 0);
        bus.cache_busy = 1'b0;
        drain("t2_drain");

        // Younger SB to the same word blocks forwarding; issue order preserved.
        bus.cache_busy = 1'b1;
        send(OP_SW, 32'h1000_0030, 32'h300, 6'd0, 32'h11, 0, 0);
        send(OP_SB, 32'h1000_0034, 32'h301, 6'd0, 32'h22, 0, 0);
        send(OP_LW, 32'h1000_0038, 32'h300, 6'd3, 32'h0, 0, 0);
        check("t3_no_fwd", bus.fwd_valid, 0);
        check("t3_count",  bus.count,     3);
        bus.cache_busy = 1'b0;
        step();
        check("t3_wr0", bus.write_en, 1);
        step();
        check("t3_wr1", bus.write_en, 1);
        step();
        check("t3_rd2", bus.read_en,  1);
        check("t3_wr2", bus.write_en, 0);
        step();
        check("t3_count_end", bus.count, 0);

        // Fill to DEPTH, reject the overflow op, then stream across the wrap.
        bus.cache_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            send((i % 2 == 0) ? OP_SW : OP_LW, 32'h4000 + i, 32'h1000 + 32'(i) * 16,
                 6'(i), 32'hA0 + i, 0, 0);
        check("t4_full_count", bus.count,    8);
        check("t4_full_ready", bus.in_ready, 0);
        send(OP_LW, 32'h4100, 32'h9000, 6'd40, 32'h0, 2, 0);
        check("t4_reject_count", bus.count, 8);
        bus.cache_busy = 1'b0;
        for (int i = 0; i < 12; i++)
            send_wait((i % 3 == 0) ? OP_SW : ((i % 3 == 1) ? OP_LB : OP_LW), 32'h5000 + i,
                      32'h2000 + 32'(i) * 16, 6'(20 + i), 32'hB000 + i);
        drain("t4_drain");
        check("t4_ready_end", bus.in_ready, 1);

        // Flush beats enqueue, issue and forward in the same cycle.
        bus.cache_busy = 1'b1;
        send(OP_SW, 32'h6000, 32'h500, 6'd0, 32'hCAFE_F00D, 0, 0);
        send(OP_LW, 32'h6004, 32'h600, 6'd1, 32'h0, 0, 0);
        send(OP_SW, 32'h6008, 32'h700, 6'd0, 32'h77, 0, 0);
        send(OP_LW, 32'h600C, 32'h800, 6'd2, 32'h0, 0, 0);
        check("t5_count", bus.count, 4);
        set_op(OP_LB, 32'h6010, 32'h500, 6'd20, 32'h0);
        bus.flush      = 1'b1;
        bus.cache_busy = 1'b0;
        exp_iss.delete();
        step();
        check("t5_count0",  bus.count,     0);
        check("t5_rd",      bus.read_en,   0);
        check("t5_wr",      bus.write_en,  0);
        check("t5_fwd",     bus.fwd_valid, 0);
        check("t5_ready",   bus.in_ready,  1);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        step();
        step();
        check("t5_still_empty", bus.count, 0);
        send(OP_LW, 32'h6020, 32'h900, 6'd21, 32'h0, 0, 0);
        step();
        check("t5_post_rd",   bus.read_en,    1);
        check("t5_post_addr", bus.address_in, 32'h900);
        step();

        // Asynchronous reset while issue is in progress.
        bus.cache_busy = 1'b1;
        send(OP_LW, 32'h7000, 32'hA00, 6'd30, 32'h0, 0, 0);
        send(OP_SW, 32'h7004, 32'hA04, 6'd0,  32'h99, 0, 0);
        send(OP_LW, 32'h7008, 32'hA08, 6'd31, 32'h0, 0, 0);
        bus.cache_busy = 1'b0;
        step();
        check("t6_pre_rd", bus.read_en, 1);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        exp_iss.delete();
        #1;
        check("t6_rd",     bus.read_en,    0);
        check("t6_wr",     bus.write_en,   0);
        check("t6_addr",   bus.address_in, 0);
        check("t6_optype", bus.optype,     0);
        check("t6_count",  bus.count,      0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        check("t6_post_count", bus.count,    0);
        check("t6_post_ready", bus.in_ready, 1);
        send(OP_LW, 32'h7100, 32'hB00, 6'd7, 32'h0, 0, 0);
        drain("t6_drain");

        step();
        check("end_iss_q", exp_iss.size(), 0);
        check("end_fwd_q", exp_fwd.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
